// File: rtl/register_sequencer.sv
// register_sequencer
//   Turns single commands (WRITE / READ / COPY / CLEAR_ALL) into cycle-level
//   accesses on the master side of a 16x8 register unit. One command is in
//   flight at a time. READ results are returned on a valid/ready response port.
//
// Ports
//   clock, reset       : clock; asynchronous active-high reset
//   cmd_valid/ready    : command handshake, ready only while idle
//   cmd_op             : 00 WRITE, 01 READ, 10 COPY, 11 CLEAR_ALL
//   cmd_addr/src/data  : destination or read slot, COPY source slot, WRITE data
//   rsp_valid/ready    : READ result handshake; rsp_data/rsp_addr held until taken
//   reg_load/addr/
//   reg_data_in        : register unit write strobe, slot and write data
//   reg_data_out       : register unit read data (one-edge latency)
//   busy               : high whenever a command is being executed
module register_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_addr,
  input  logic [3:0] cmd_src,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_addr,
  output logic       reg_load,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_data_in,
  input  logic [7:0] reg_data_out,
  output logic       busy
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_RD_ADDR, S_RD_CAP, S_RSP,
    S_CP_ADDR, S_CP_CAP, S_CP_WR, S_CLR
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] src_q, src_d;
  logic [7:0] data_q, data_d;
  logic [7:0] temp_q, temp_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [3:0] rsp_addr_q, rsp_addr_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      src_q       <= '0;
      data_q      <= '0;
      temp_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      src_q       <= src_d;
      data_q      <= data_d;
      temp_q      <= temp_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    src_d       = src_q;
    data_d      = data_q;
    temp_d      = temp_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    reg_load    = 1'b0;
    reg_addr    = '0;
    reg_data_in = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          src_d  = cmd_src;
          data_d = cmd_data;
          unique case (cmd_op)
            OP_WRITE: state_d = S_WR;
            OP_READ:  state_d = S_RD_ADDR;
            OP_COPY:  state_d = S_CP_ADDR;
            OP_CLEAR: begin
              state_d = S_CLR;
              cnt_d   = '0;
            end
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_WR: begin
        reg_load    = 1'b1;
        reg_addr    = addr_q;
        reg_data_in = data_q;
        state_d     = S_IDLE;
      end
      // Address is held for two cycles: the unit latches data_out at the
      // first edge, and the sequencer samples it at the second.
      S_RD_ADDR: begin
        reg_addr = addr_q;
        state_d  = S_RD_CAP;
      end
      S_RD_CAP: begin
        reg_addr    = addr_q;
        rsp_data_d  = reg_data_out;
        rsp_addr_d  = addr_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_CP_ADDR: begin
        reg_addr = src_q;
        state_d  = S_CP_CAP;
      end
      S_CP_CAP: begin
        reg_addr = src_q;
        temp_d   = reg_data_out;
        state_d  = S_CP_WR;
      end
      S_CP_WR: begin
        reg_load    = 1'b1;
        reg_addr    = addr_q;
        reg_data_in = temp_q;
        state_d     = S_IDLE;
      end
      S_CLR: begin
        reg_load = 1'b1;
        reg_addr = cnt_q;
        // Stop at slot 15 and leave the counter parked at zero.
        if (cnt_q == 4'd15) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_register_sequencer.sv
// Bench for register_sequencer: models the 16x8 register unit, keeps a
// command-level reference image of the slots, and runs directed plus
// randomized command sequences against it.
module tb_register_sequencer;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_CP  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr, cmd_src;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_addr;
  logic       reg_load;
  logic [3:0] reg_addr;
  logic [7:0] reg_data_in, reg_data_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] ru_mem  [16];   // register unit contents
  logic [7:0] ref_mem [16];   // expected contents, command level

  always #5 clock = ~clock;

  // Register unit: read data reflects pre-write contents of the addressed slot.
  always @(posedge clock) begin
    reg_data_out <= ru_mem[reg_addr];
    if (reg_load) ru_mem[reg_addr] <= reg_data_in;
  end

  register_sequencer dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_src(cmd_src), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .reg_load(reg_load), .reg_addr(reg_addr), .reg_data_in(reg_data_in),
    .reg_data_out(reg_data_out), .busy(busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from a negedge, run it to completion, check it and
  // update the reference image. dly = extra cycles rsp_ready stays low.
  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] s,
                      input logic [7:0] d, input int dly);
    int n, lat, w, exp_lat;
    bit seen;
    logic [7:0] exp_rd;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clock); n++; end
    chk("cmd_ready_wait", int'(cmd_ready), 1);
    exp_rd    = ref_mem[a];
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_src = s; cmd_data = d;
    rsp_ready = (dly == 0);
    @(negedge clock);
    // Scramble the command bus: the DUT must work from its captured copy.
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 4'($urandom);
    cmd_src = 4'($urandom); cmd_data = 8'($urandom);
    lat = 1; w = 0; seen = 0;
    while (busy && lat < 64) begin
      chk("cmd_ready_busy", int'(cmd_ready), 0);
      if (op == OP_WR && lat == 1) begin
        chk("wr_load", int'(reg_load), 1);
        chk("wr_addr", int'(reg_addr), int'(a));
        chk("wr_data", int'(reg_data_in), int'(d));
      end
      if (op == OP_CLR) begin
        chk("clr_load", int'(reg_load), 1);
        chk("clr_addr", int'(reg_addr), lat - 1);
        chk("clr_data", int'(reg_data_in), 0);
      end
      if (rsp_valid) begin
        if (!seen) chk("rd_rsp_timing", lat, 3);
        seen = 1;
        chk("rd_data", int'(rsp_data), int'(exp_rd));
        chk("rd_addr", int'(rsp_addr), int'(a));
        rsp_ready = (w >= dly);
        w++;
      end
      @(negedge clock);
      lat++;
    end
    chk("rsp_seen", int'(seen), int'(op == OP_RD));
    case (op)
      OP_WR:   exp_lat = 1;
      OP_RD:   exp_lat = 3 + dly;
      OP_CP:   exp_lat = 3;
      default: exp_lat = 16;
    endcase
    chk("latency", lat - 1, exp_lat);
    chk("rsp_valid_after", int'(rsp_valid), 0);
    chk("load_idle", int'(reg_load), 0);
    rsp_ready = 1'b0;
    case (op)
      OP_WR:   ref_mem[a] = d;
      OP_CP:   ref_mem[a] = ref_mem[s];
      OP_CLR:  for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      default: ;
    endcase
  endtask

  initial begin
    int n;
    logic [1:0] rop;
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_addr = '0; cmd_src = '0; cmd_data = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

    // Reset state
    @(negedge clock); @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_addr", int'(rsp_addr), 0);
    chk("rst_load", int'(reg_load), 0);
    chk("rst_addr", int'(reg_addr), 0);
    chk("rst_data_in", int'(reg_data_in), 0);
    reset = 1'b0;
    chk("rst_cmd_ready", int'(cmd_ready), 1);

    // First command right after release; also initialises the unit.
    send(OP_CLR, 4'd0, 4'd0, 8'd0, 0);

    // WRITE then READ
    send(OP_WR, 4'd3, 4'd0, 8'hA5, 0);
    send(OP_RD, 4'd3, 4'd0, 8'd0, 0);

    // Back-to-back WRITEs with cmd_valid held throughout
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cmd_op = OP_WR; cmd_addr = 4'(10 + k); cmd_data = 8'(8'h50 + k);
      @(negedge clock);
      chk("b2b_busy", int'(busy), 1);
      chk("b2b_addr", int'(reg_addr), 10 + k);
      @(negedge clock);
      chk("b2b_ready", int'(cmd_ready), 1);
      ref_mem[10 + k] = 8'(8'h50 + k);
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) send(OP_RD, 4'(10 + k), 4'd0, 8'd0, 0);

    // COPY
    send(OP_WR, 4'd2, 4'd0, 8'h3C, 0);
    send(OP_CP, 4'd9, 4'd2, 8'd0, 0);
    send(OP_RD, 4'd9, 4'd0, 8'd0, 1);
    send(OP_RD, 4'd2, 4'd0, 8'd0, 0);
    send(OP_WR, 4'd4, 4'd0, 8'h6B, 0);
    send(OP_CP, 4'd4, 4'd4, 8'd0, 0);
    send(OP_RD, 4'd4, 4'd0, 8'd0, 0);
    chk("copy_self_mem", int'(ru_mem[4]), 8'h6B);

    // Fill, then a stalled READ with another command offered meanwhile
    for (int i = 0; i < 16; i++) send(OP_WR, 4'(i), 4'd0, 8'(8'h10 + i), 0);
    cmd_valid = 1'b1; cmd_op = OP_RD; cmd_addr = 4'd7; rsp_ready = 1'b0;
    @(negedge clock);
    cmd_op = OP_WR; cmd_addr = 4'd7; cmd_data = 8'hEE;
    @(negedge clock); @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp_valid", int'(rsp_valid), 1);
      chk("stall_rsp_data", int'(rsp_data), 8'h17);
      chk("stall_rsp_addr", int'(rsp_addr), 7);
      chk("stall_busy", int'(busy), 1);
      chk("stall_cmd_ready", int'(cmd_ready), 0);
      @(negedge clock);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clock);
    chk("stall_release_busy", int'(busy), 0);
    chk("stall_release_valid", int'(rsp_valid), 0);
    rsp_ready = 1'b0;
    chk("stall_no_side_effect", int'(ru_mem[7]), 8'h17);

    // CLEAR_ALL then read every slot back
    send(OP_CLR, 4'd0, 4'd0, 8'd0, 0);
    for (int i = 0; i < 16; i++) send(OP_RD, 4'(i), 4'd0, 8'd0, 0);

    // Reset in the middle of CLEAR_ALL at counter 6
    for (int i = 0; i < 16; i++) send(OP_WR, 4'(i), 4'd0, 8'(8'h10 + i), 0);
    cmd_valid = 1'b1; cmd_op = OP_CLR;
    @(negedge clock);
    cmd_valid = 1'b0;
    n = 0;
    while (!(reg_load && reg_addr == 4'd6) && n < 32) begin @(negedge clock); n++; end
    chk("clr_reach6", int'(reg_addr), 6);
    reset = 1'b1;
    #1;
    chk("clr_rst_load", int'(reg_load), 0);
    chk("clr_rst_busy", int'(busy), 0);
    chk("clr_rst_addr", int'(reg_addr), 0);
    @(negedge clock); @(negedge clock);
    for (int i = 0; i < 16; i++)
      chk("clr_rst_mem", int'(ru_mem[i]), (i < 6) ? 0 : 8'h10 + i);
    for (int i = 0; i < 16; i++) ref_mem[i] = (i < 6) ? 8'h00 : 8'(8'h10 + i);
    reset = 1'b0;
    chk("clr_rst_ready", int'(cmd_ready), 1);
    send(OP_RD, 4'd6, 4'd0, 8'd0, 0);

    // Reset while a response is pending discards it
    cmd_valid = 1'b1; cmd_op = OP_RD; cmd_addr = 4'd8; rsp_ready = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock); @(negedge clock);
    chk("pend_valid", int'(rsp_valid), 1);
    reset = 1'b1;
    #1;
    chk("pend_rst_valid", int'(rsp_valid), 0);
    chk("pend_rst_data", int'(rsp_data), 0);
    @(negedge clock);
    reset = 1'b0;

    // Randomized command mix
    for (int k = 0; k < 60; k++) begin
      n = $urandom_range(0, 9);
      rop = (n < 4) ? OP_WR : (n < 7) ? OP_RD : (n < 9) ? OP_CP : OP_CLR;
      send(rop, 4'($urandom), 4'($urandom), 8'($urandom), $urandom_range(0, 3));
    end
    for (int i = 0; i < 16; i++) send(OP_RD, 4'(i), 4'd0, 8'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_sequencer.md
REGISTER_SEQUENCER -- requirements
Module: register_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when high with cmd_valid at a rising edge.
REQ-003 SHALL have: cmd_op  in  2  operation, 00 WRITE, 01 READ, 10 COPY, 11 CLEAR_ALL.
REQ-004 SHALL have: cmd_addr  in  4  destination/read slot; cmd_src  in  4  COPY source slot; cmd_data  in  8  WRITE data.
REQ-005 SHALL have: rsp_valid  out  1  read result available; rsp_ready  in  1  consumer accepts result; rsp_data  out  8  read value; rsp_addr  out  4  slot read.
REQ-006 SHALL have: reg_load  out  1; reg_addr  out  4; reg_data_in  out  8; reg_data_out  in  8 -- master side of the 16x8 register unit port (load, addr, data_in, data_out).
REQ-007 SHALL have: busy  out  1  high whenever state is not IDLE.

Function
REQ-008 SHALL capture cmd_op/addr/src/data into internal registers on the accept edge; reg_* outputs SHALL be driven only from registered state, never combinationally from cmd_*.
REQ-009 cmd_ready SHALL be high only in IDLE; at most one command in flight.
REQ-010 States SHALL be IDLE, WR, RD_ADDR, RD_CAP, RSP, CP_ADDR, CP_CAP, CP_WR, CLR.
REQ-011 Register unit read latency is one edge: data_out updates at the edge where reg_addr is presented and reflects the pre-write contents of that slot; sequencer SHALL sample reg_data_out on the following edge.
REQ-012 WRITE: accept edge E0 -> WR for one cycle with reg_load=1, reg_addr=cmd_addr, reg_data_in=cmd_data; slot written at E1; IDLE after E1; no response.
REQ-013 READ: E0 -> RD_ADDR (reg_addr=cmd_addr, reg_load=0); E1 -> RD_CAP (reg_addr held); at E2 rsp_data<=reg_data_out, rsp_addr<=cmd_addr, rsp_valid<=1, state RSP.
REQ-014 RSP: rsp_valid, rsp_data, rsp_addr SHALL hold stable until rsp_valid&&rsp_ready at an edge; then rsp_valid<=0, state IDLE on that edge.
REQ-015 COPY: E0 -> CP_ADDR (reg_addr=cmd_src); E1 -> CP_CAP; at E2 temp<=reg_data_out, state CP_WR; CP_WR drives reg_load=1, reg_addr=cmd_addr, reg_data_in=temp; IDLE after E3; no response.
REQ-016 COPY with cmd_src==cmd_addr SHALL execute the full sequence, rewriting the same value.
REQ-017 CLEAR_ALL: CLR for exactly 16 cycles with 4-bit counter 0..15, reg_load=1, reg_addr=counter, reg_data_in=0; after the counter=15 write edge, state IDLE and counter 0; no wrap beyond 15.
REQ-018 reg_load SHALL be 0 in every state except WR, CP_WR, CLR; reg_addr and reg_data_in SHALL be 0 in IDLE.
REQ-019 cmd_valid while busy SHALL be ignored (not captured, no side effect); the source holds it until accepted.
REQ-020 Latency from accept edge to IDLE: WRITE 1, READ 2 + response wait, COPY 3, CLEAR_ALL 16 cycles.

Reset
REQ-021 On reset assertion, state SHALL go to IDLE immediately; cmd_ready=1 after release; busy, rsp_valid, reg_load=0; rsp_data, rsp_addr, reg_addr, reg_data_in, temp, counter=0.
REQ-022 Reset mid-operation SHALL abandon the operation with no further register unit writes; a pending response SHALL be discarded.
REQ-023 First command SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-024 WRITE addr 3 data 0xA5, then READ addr 3 with rsp_ready=1 -> rsp_valid exactly 2 edges after READ accept, rsp_data=0xA5, rsp_addr=3.
REQ-025 READ addr 7 with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data, busy held, cmd_ready=0; new cmd_valid ignored; rsp_ready=1 -> IDLE next edge.
REQ-026 WRITE 0x3C to slot 2, COPY src 2 dst 9, READ 9 -> 0x3C; slot 2 still 0x3C; COPY 4->4 leaves slot 4 unchanged.
REQ-027 Fill slots 0..15 with 0x10+i, CLEAR_ALL -> reg_load high 16 consecutive cycles, addr 0..15; all 16 reads return 0x00.
REQ-028 Assert reset during CLR at counter=6 -> reg_load=0 immediately, busy=0, slots 7..15 not written by sequencer, cmd_ready=1 after release.
REQ-029 Back-to-back WRITE commands with cmd_valid held -> accepted every 2 cycles, each write visible on the following READ.
